// File: rtl/conv_window_streamer.sv
// -----------------------------------------------------------------------------
// conv_window_streamer
//
// Takes a raster-ordered pixel stream of a square N x N image and produces
// every K x K convolution window at stride S, one per output transfer. The
// previous K-1 image rows are kept in on-chip line buffers, so each pixel is
// read from upstream exactly once. The most recent K columns sit in a small
// shift register. A window leaves on the cycle after the pixel that completes
// it (its bottom-right pixel) is accepted.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high reset
//   start        one-cycle frame request, only looked at in IDLE
//   img_size     image side N (latched on an accepted start)
//   filter_size  filter side K, 3 or 5 (latched on an accepted start)
//   stride       window stride S, 1 or 2 (latched on an accepted start)
//   in_valid     upstream pixel valid
//   in_data      signed pixel, row-major raster order
//   in_ready     this block takes the pixel this cycle
//   out_valid    window holds a valid window
//   out_ready    downstream takes the window this cycle
//   window       MAX_K*MAX_K elements, element e at [e*DATA_W +: DATA_W];
//                element ky*MAX_K+kx = pixel(top+ky, left+kx), unused = 0
//   done         one-cycle pulse when a frame has fully drained
//   cfg_err      one-cycle pulse after a start with an illegal configuration
// -----------------------------------------------------------------------------
module conv_window_streamer #(
  parameter int DATA_W  = 16,
  parameter int MAX_IMG = 32,
  parameter int MAX_K   = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [15:0]                     img_size,
  input  logic [15:0]                     filter_size,
  input  logic [1:0]                      stride,
  input  logic                            in_valid,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [MAX_K*MAX_K*DATA_W-1:0]   window,
  output logic                            done,
  output logic                            cfg_err
);

  localparam int CW  = $clog2(MAX_IMG) + 1;      // row/column counter width
  localparam int AW  = $clog2(MAX_IMG);          // line-buffer address width
  localparam int NLB = MAX_K - 1;                // number of line buffers
  localparam int NE  = MAX_K * MAX_K;            // window elements
  localparam int WW  = NE * DATA_W;              // window bus width
  localparam int SRW = (MAX_K - 1) * MAX_K * DATA_W;  // stored older columns

  localparam logic [15:0] MAX_IMG_W = 16'(MAX_IMG);
  localparam logic        K5_OK     = (MAX_K >= 5);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  genvar gi;

  // ---------------------------------------------------------------------------
  // State and latched configuration
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [CW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [CW-1:0]   r_last_idx;   // N-1
  logic [CW-1:0]   r_k;
  logic            r_s2;         // stride is 2
  logic            r_out_valid;
  logic [WW-1:0]   r_window;
  logic            r_done;
  logic            r_cfg_err;
  logic [SRW-1:0]  r_sr;         // columns aged 1..MAX_K-1, MAX_K rows each

  // ---------------------------------------------------------------------------
  // Handshakes and counter arithmetic
  // ---------------------------------------------------------------------------
  logic            w_cfg_legal;
  logic            w_in_ready;
  logic            w_pix_xfer;
  logic            w_col_last;
  logic            w_row_last;
  logic [CW-1:0]   w_col_next;
  logic [CW-1:0]   w_km1;
  logic            w_row_phase_ok;
  logic            w_col_phase_ok;
  logic            w_emit;
  logic [AW-1:0]   w_rd_col;

  assign w_cfg_legal = ((filter_size == 16'd3) || ((filter_size == 16'd5) && K5_OK)) &&
                       ((stride == 2'd1) || (stride == 2'd2)) &&
                       (img_size >= filter_size) &&
                       (img_size <= MAX_IMG_W);

  assign w_in_ready = (r_state == S_STREAM) && (!r_out_valid || out_ready);
  assign w_pix_xfer = in_valid && w_in_ready;

  assign w_col_last = (r_col == r_last_idx);
  assign w_row_last = (r_row == r_last_idx);
  assign w_col_next = w_col_last ? '0 : r_col + CW'(1);
  assign w_km1      = r_k - CW'(1);

  // With S = 2 only even offsets from K-1 start a window; the parity of
  // (r - (K-1)) is just the XOR of the two low bits.
  assign w_row_phase_ok = !r_s2 || !(r_row[0] ^ w_km1[0]);
  assign w_col_phase_ok = !r_s2 || !(r_col[0] ^ w_km1[0]);

  assign w_emit = w_pix_xfer && (r_row >= w_km1) && (r_col >= w_km1) &&
                  w_row_phase_ok && w_col_phase_ok;

  // Line-buffer reads are registered, so the address runs one pixel ahead:
  // when a pixel transfers, fetch the column of the next expected pixel.
  // Column c is only ever written by the transfer of column c itself, so the
  // prefetched word is still current when that pixel arrives.
  always_comb begin
    w_rd_col = r_col[AW-1:0];
    if (r_state == S_IDLE) begin
      w_rd_col = '0;
    end else if (w_pix_xfer) begin
      w_rd_col = w_col_next[AW-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: buffer 0 holds row r-1, buffer i holds row r-1-i. On each
  // accepted pixel the column cascades one buffer down, so the old contents
  // of buffer i move into buffer i+1 and the new pixel lands in buffer 0.
  // ---------------------------------------------------------------------------
  logic [NLB*DATA_W-1:0] w_lb_q;

  for (gi = 0; gi < NLB; gi++) begin : g_lb
    logic [DATA_W-1:0] r_mem [MAX_IMG];
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] w_wdata;

    if (gi == 0) begin : g_first
      assign w_wdata = in_data;
    end else begin : g_chain
      assign w_wdata = w_lb_q[(gi-1)*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
      if (w_pix_xfer) begin
        r_mem[r_col[AW-1:0]] <= w_wdata;
      end
      r_q <= r_mem[w_rd_col];
    end

    assign w_lb_q[gi*DATA_W +: DATA_W] = r_q;
  end

  // ---------------------------------------------------------------------------
  // Column shift register. Slot (age x, depth j) sits at (x*MAX_K + j);
  // depth 0 is the current row, depth j is row r-j. Age 0 is the column
  // being accepted right now, built from the input pixel and buffer outputs.
  // ---------------------------------------------------------------------------
  logic [WW-1:0] w_sr_next;

  for (gi = 0; gi < MAX_K; gi++) begin : g_col
    if (gi == 0) begin : g_new
      assign w_sr_next[gi*DATA_W +: DATA_W] = in_data;
    end else begin : g_old
      assign w_sr_next[gi*DATA_W +: DATA_W] = w_lb_q[(gi-1)*DATA_W +: DATA_W];
    end
  end
  assign w_sr_next[WW-1:MAX_K*DATA_W] = r_sr;

  // ---------------------------------------------------------------------------
  // Window assembly. For a K-wide window ending at the current pixel, element
  // (ky, kx) is the pixel at age K-1-kx and depth K-1-ky. Only K = 3 and
  // K = 5 are legal, so both fixed mappings are built and one is selected.
  // ---------------------------------------------------------------------------
  logic [WW-1:0] w_win3;
  logic [WW-1:0] w_win5;
  logic [WW-1:0] w_win_next;

  for (gi = 0; gi < NE; gi++) begin : g_win
    localparam int KY = gi / MAX_K;
    localparam int KX = gi % MAX_K;

    if ((KY < 3) && (KX < 3)) begin : g_k3
      localparam int SRC3 = ((2 - KX) * MAX_K + (2 - KY)) * DATA_W;
      assign w_win3[gi*DATA_W +: DATA_W] = w_sr_next[SRC3 +: DATA_W];
    end else begin : g_k3_zero
      assign w_win3[gi*DATA_W +: DATA_W] = '0;
    end

    if ((MAX_K >= 5) && (KY < 5) && (KX < 5)) begin : g_k5
      localparam int SRC5 = ((4 - KX) * MAX_K + (4 - KY)) * DATA_W;
      assign w_win5[gi*DATA_W +: DATA_W] = w_sr_next[SRC5 +: DATA_W];
    end else begin : g_k5_zero
      assign w_win5[gi*DATA_W +: DATA_W] = '0;
    end
  end

  assign w_win_next = (r_k == CW'(5)) ? w_win5 : w_win3;

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_last_idx  <= '0;
      r_k         <= '0;
      r_s2        <= 1'b0;
      r_out_valid <= 1'b0;
      r_window    <= '0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_sr        <= '0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;

      if (w_pix_xfer) begin
        r_sr <= w_sr_next[SRW-1:0];
      end

      case (r_state)
        S_IDLE: begin
          // The cycle carrying done is still IDLE; a start there is ignored
          // so the next frame begins no earlier than the cycle after done.
          if (start && !r_done) begin
            if (w_cfg_legal) begin
              r_last_idx <= img_size[CW-1:0] - CW'(1);
              r_k        <= filter_size[CW-1:0];
              r_s2       <= (stride == 2'd2);
              r_row      <= '0;
              r_col      <= '0;
              r_state    <= S_STREAM;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end

        S_STREAM: begin
          if (w_pix_xfer) begin
            r_col <= w_col_next;
            if (w_col_last) begin
              r_row <= r_row + CW'(1);
              if (w_row_last) begin
                r_state <= S_DRAIN;
              end
            end
          end
          // A new window may replace one that is leaving this same cycle.
          if (w_emit) begin
            r_out_valid <= 1'b1;
            r_window    <= w_win_next;
          end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
        end

        S_DRAIN: begin
          if (!r_out_valid || out_ready) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign window    = r_window;
  assign done      = r_done;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_conv_window_streamer.sv
// -----------------------------------------------------------------------------
// tb_conv_window_streamer
//
// Drives frames of pixels into conv_window_streamer and checks every window,
// the in_ready/out_valid handshake, window stability during stalls, done
// timing, cfg_err pulses and reset behaviour. Expected windows come from a
// plain enumeration of top-left corners over an image array.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv_window_streamer;

  localparam int DATA_W  = 16;
  localparam int MAX_IMG = 32;
  localparam int MAX_K   = 5;
  localparam int WW      = MAX_K * MAX_K * DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [15:0]       img_size;
  logic [15:0]       filter_size;
  logic [1:0]        stride;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [WW-1:0]     window;
  logic              done;
  logic              cfg_err;

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] pix [MAX_IMG][MAX_IMG];
  logic [WW-1:0]     exp_q [$];

  always #5 clk = ~clk;

  conv_window_streamer #(
    .DATA_W (DATA_W),
    .MAX_IMG(MAX_IMG),
    .MAX_K  (MAX_K)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .img_size   (img_size),
    .filter_size(filter_size),
    .stride     (stride),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .window     (window),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  // Reference: fill the image, then list every window by its top-left corner.
  task automatic build_model(input int n, input int k, input int s, input bit rnd);
    logic [WW-1:0] w;
    exp_q.delete();
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        pix[r][c] = rnd ? DATA_W'($urandom) : DATA_W'(r * n + c);
      end
    end
    for (int top = 0; top + k <= n; top += s) begin
      for (int left = 0; left + k <= n; left += s) begin
        w = '0;
        for (int ky = 0; ky < k; ky++) begin
          for (int kx = 0; kx < k; kx++) begin
            w[(ky * MAX_K + kx) * DATA_W +: DATA_W] = pix[top + ky][left + kx];
          end
        end
        exp_q.push_back(w);
      end
    end
  endtask

  // Runs one frame. Called and returns at (or just after) a falling edge.
  // abort_px > 0 returns early once that many pixels have been accepted.
  task automatic run_frame(input string name, input int n, input int k, input int s,
                           input bit rnd, input int in_pct, input int out_pct,
                           input int abort_px);
    int px, cyc, budget, r, c, n_win;
    bit got_done, m_ov, exp_done, hold, pix_x, win_x, emit, draining, exp_ready;
    logic [WW-1:0] hold_win, want;
    px = 0; cyc = 0; n_win = 0;
    got_done = 0; m_ov = 0; exp_done = 0; hold = 0;
    hold_win = '0;
    budget = 20 * n * n + 200;
    build_model(n, k, s, rnd);

    img_size = 16'(n); filter_size = 16'(k); stride = 2'(s);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);

    while (!got_done) begin
      @(negedge clk);
      if (abort_px > 0 && px >= abort_px) begin
        start = 1'b0; in_valid = 1'b0;
        break;
      end
      if (cyc >= budget) begin
        tests++; fails++;
        $display("FAIL %s timeout: got %0d windows want %0d", name, n_win, n_win + exp_q.size());
        break;
      end
      cyc++;
      // Stray starts and garbage config while streaming must change nothing.
      start       = (px < n * n) && ($urandom_range(0, 9) == 0);
      img_size    = 16'($urandom);
      filter_size = 16'($urandom);
      stride      = 2'($urandom);
      in_valid    = (px < n * n) && ($urandom_range(1, 100) <= in_pct);
      in_data     = in_valid ? pix[px / n][px % n] : DATA_W'($urandom);
      out_ready   = ($urandom_range(1, 100) <= out_pct);
      #1;

      tests++;
      if (done !== exp_done) begin
        fails++;
        $display("FAIL %s done cyc%0d: got %b want %b", name, cyc, done, exp_done);
      end
      if (exp_done) begin
        got_done = 1;
        tests++;
        if (exp_q.size() != 0) begin
          fails++;
          $display("FAIL %s win_count: got %0d want %0d", name, n_win, n_win + exp_q.size());
        end
      end
      tests++;
      if (cfg_err !== 1'b0) begin
        fails++;
        $display("FAIL %s cfg_err cyc%0d: got %b want 0", name, cyc, cfg_err);
      end
      tests++;
      if (out_valid !== m_ov) begin
        fails++;
        $display("FAIL %s out_valid cyc%0d: got %b want %b", name, cyc, out_valid, m_ov);
      end
      exp_ready = (px < n * n) && (!m_ov || out_ready);
      tests++;
      if (in_ready !== exp_ready) begin
        fails++;
        $display("FAIL %s in_ready cyc%0d: got %b want %b", name, cyc, in_ready, exp_ready);
      end
      if (hold) begin
        tests++;
        if (window !== hold_win) begin
          fails++;
          $display("FAIL %s stall_hold cyc%0d: got %h want %h", name, cyc, window, hold_win);
        end
      end

      win_x = out_valid && out_ready;
      pix_x = in_valid && in_ready;
      if (win_x) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL %s extra_win%0d: got %h want none", name, n_win, window);
        end else begin
          want = exp_q.pop_front();
          if (window !== want) begin
            fails++;
            $display("FAIL %s win%0d: got %h want %h", name, n_win, window, want);
          end
        end
        n_win++;
      end
      hold     = out_valid && !out_ready;
      hold_win = window;

      // Model step: a window is due when the accepted pixel is the
      // bottom-right corner of a stride-aligned K x K block.
      r = px / n; c = px % n;
      emit = pix_x && (r >= k - 1) && (c >= k - 1) &&
             (((r - k + 1) % s) == 0) && (((c - k + 1) % s) == 0);
      draining = (px == n * n);
      exp_done = draining && !got_done && (!m_ov || out_ready);
      if (emit) m_ov = 1'b1;
      else if (m_ov && out_ready) m_ov = 1'b0;
      if (pix_x) px++;
    end

    if (got_done) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      tests++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL %s done_width: got %b want 0", name, done);
      end
      tests++;
      if (in_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s idle_in_ready: got %b want 0", name, in_ready);
      end
    end
  endtask

  task automatic check_zero_outputs(input string name);
    tests++;
    if ({in_ready, out_valid, done, cfg_err} !== 4'b0000 || window !== '0) begin
      fails++;
      $display("FAIL %s: got rdy=%b ov=%b done=%b err=%b win=%h want all zero",
               name, in_ready, out_valid, done, cfg_err, window);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; img_size = 16'd8; filter_size = 16'd3; stride = 2'd1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_zero_outputs("reset_state");
    reset = 1'b0;
  endtask

  task automatic test_full_frame();
    run_frame("full_32_3_1", 32, 3, 1, 1'b0, 100, 100, 0);
  endtask

  task automatic test_stride2();
    run_frame("stride2_9_5_2", 9, 5, 2, 1'b0, 100, 100, 0);
    run_frame("trailing_10_5_2", 10, 5, 2, 1'b1, 100, 100, 0);
  endtask

  task automatic test_stall();
    run_frame("stall_8_3_1", 8, 3, 1, 1'b1, 50, 50, 0);
    run_frame("stall_9_5_1", 9, 5, 1, 1'b1, 70, 40, 0);
  endtask

  task automatic test_cfg_err();
    int ns [4] = '{8, 3, 8, 33};
    int ks [4] = '{4, 5, 3, 3};
    int ss [4] = '{1, 1, 3, 1};
    for (int i = 0; i < 4; i++) begin
      img_size = 16'(ns[i]); filter_size = 16'(ks[i]); stride = 2'(ss[i]);
      start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      #1;
      tests++;
      if (cfg_err !== 1'b1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL cfg_err_pulse%0d: got err=%b rdy=%b want err=1 rdy=0", i, cfg_err, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      tests++;
      if (cfg_err !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL cfg_err_after%0d: got err=%b rdy=%b done=%b want 0 0 0",
                 i, cfg_err, in_ready, done);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_8_5_1", 8, 5, 1, 1'b1, 80, 70, 0);
    run_frame("b2b_12_3_2", 12, 3, 2, 1'b1, 100, 40, 0);
    run_frame("b2b_5_5_1", 5, 5, 1, 1'b0, 100, 100, 0);
  endtask

  task automatic test_reset_abort();
    run_frame("abort_32_3_1", 32, 3, 1, 1'b1, 100, 100, 100);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_zero_outputs("abort_reset_state");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      tests++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL abort_no_done%0d: got done=%b ov=%b want 0 0", i, done, out_valid);
      end
    end
    run_frame("post_abort_16_3_1", 16, 3, 1, 1'b1, 80, 70, 0);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stride2();
    test_stall();
    test_cfg_err();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_window_streamer.md
CONV_WINDOW_STREAMER -- requirements
Module: conv_window_streamer

Interface
REQ-001 Parameter DATA_W, 16, pixel and window-element width in bits (signed).
REQ-002 Parameter MAX_IMG, 32, largest supported square image side.
REQ-003 Parameter MAX_K, 5, largest supported square filter side; window port carries MAX_K*MAX_K elements.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
REQ-007 img_size  input  16  image side N; latched on accepted start.
REQ-008 filter_size  input  16  filter side K, legal values 3 or 5 (never above MAX_K); latched on accepted start.
REQ-009 stride  input  2  window stride S, legal values 1 or 2; latched on accepted start.
REQ-010 in_valid  input  1  pixel on in_data is valid.
REQ-011 in_data  input  DATA_W  signed pixel, raster order (row-major, row 0 first).
REQ-012 in_ready  output  1  block accepts pixel this cycle.
REQ-013 out_valid  output  1  window output holds a valid window.
REQ-014 out_ready  input  1  consumer accepts window this cycle.
REQ-015 window  output  MAX_K*MAX_K*DATA_W  flattened window; element e at bits [e*DATA_W +: DATA_W].
REQ-016 done  output  1  one-cycle pulse at frame completion.
REQ-017 cfg_err  output  1  one-cycle pulse on start with illegal configuration.

Function
REQ-018 Pixel transfer SHALL occur on in_valid && in_ready; window transfer SHALL occur on out_valid && out_ready.
REQ-019 FSM states SHALL be IDLE, STREAM, DRAIN; reset enters IDLE.
REQ-020 IDLE + start with legal config (K in {3,5}, S in {1,2}, K <= N <= MAX_IMG) -> STREAM; row/column counters cleared, config latched.
REQ-021 IDLE + start with illegal config -> cfg_err high next cycle for exactly one cycle; state stays IDLE.
REQ-022 start outside IDLE SHALL be ignored; config inputs outside the start cycle SHALL have no effect.
REQ-023 in_ready SHALL be high only in STREAM and only when (!out_valid || out_ready); low in IDLE and DRAIN.
REQ-024 K-1 line buffers of MAX_IMG entries each plus a KxK shift register SHALL retain the previous K-1 rows; no pixel re-read from upstream.
REQ-025 Accepting pixel (r,c) with r >= K-1, c >= K-1, (r-K+1) mod S == 0 and (c-K+1) mod S == 0 SHALL produce the window with top-left (r-K+1, c-K+1).
REQ-026 Latency: that window SHALL appear with out_valid high on the cycle after the pixel transfer.
REQ-027 Window layout: element ky*MAX_K+kx = pixel(top+ky, left+kx) for ky,kx < K; all elements with ky >= K or kx >= K SHALL be zero.
REQ-028 window and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-029 Windows per frame SHALL equal W*W with W = floor((N-K)/S)+1; trailing rows/columns not covered by the stride SHALL produce no window.
REQ-030 Column counter SHALL wrap 0 after N-1 and increment row; no window SHALL combine pixels from different row ends (no horizontal wrap-around).
REQ-031 After pixel (N-1,N-1) transfers, state SHALL go DRAIN; once no window is pending (out_valid low, or transferring that cycle), done SHALL pulse for one cycle and state SHALL return to IDLE.
REQ-032 A new start SHALL be accepted earliest the cycle after done.
REQ-033 Arithmetic: counters at least clog2(MAX_IMG)+1 bits; no pixel value modification (pass-through, sign preserved).

Reset
REQ-034 On reset: state IDLE, counters 0, in_ready 0, out_valid 0, window all-zero, done 0, cfg_err 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame on the next edge with no done pulse; line-buffer contents need not be cleared.
REQ-036 First frame after reset SHALL behave identically to a frame after a completed frame.

Verification
REQ-037 N=32,K=3,S=1, pixel=r*32+c, out_ready=1 -> 900 windows; first = {0,1,2,32,33,34,64,65,66}, rest zero; last top-left (29,29); one done pulse.
REQ-038 N=9,K=5,S=2 -> 9 windows, top-lefts (0,0),(0,2),(0,4),(2,0)...(4,4); first element 0 = pixel 0, element 24 = pixel 40.
REQ-039 N=10,K=5,S=2 -> exactly 9 windows; no window touches row 9 or column 9.
REQ-040 N=8,K=3,S=1 with random out_ready (50%) and random in_valid -> 36 windows, identical sequence to no-stall run; window stable during every stall.
REQ-041 start with K=4, then K=5,N=3, then S=3 -> cfg_err pulse each time, in_ready stays 0, no done.
REQ-042 reset asserted after 100 pixels of N=32 frame, then new N=16,K=3,S=1 frame -> all outputs zero after reset, no done for aborted frame, 196 correct windows in new frame.
